// File: rtl/pipelined_datapath_if.sv
// Instruction/control handshake, EX-stage results, load data and write-back port of pipelined_datapath.
interface pipelined_datapath_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic             ALUSrc;
    logic             RegWrite;
    logic             RegDst;
    logic             MemToReg;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] out32;
    logic             Zero;
    logic [WIDTH-1:0] mem_rdata;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    // Control unit, fetch and data memory side
    modport master (
        output in_valid, instruction, ALUSrc, RegWrite, RegDst, MemToReg, ALUControl, mem_rdata,
        input  in_ready, ALUResult, out32, Zero, wb_valid, wb_addr, wb_data
    );

    // Datapath side
    modport slave (
        input  in_valid, instruction, ALUSrc, RegWrite, RegDst, MemToReg, ALUControl, mem_rdata,
        output in_ready, ALUResult, out32, Zero, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/pipelined_datapath.sv
// Three-stage (ID, EX, WB) register-file/ALU datapath with operand forwarding and load-use stall.
module pipelined_datapath #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_datapath_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef logic [AW-1:0]    ridx_t;
    typedef logic [WIDTH-1:0] word_t;

    // Architectural state
    word_t rf [NREGS];

    // ID/EX pipeline register
    logic       ex_valid;
    logic       ex_regwrite;
    logic       ex_memtoreg;
    ridx_t      ex_dest;
    logic [3:0] ex_aluctl;
    word_t      ex_a;
    word_t      ex_b;
    word_t      ex_store;

    // EX/WB pipeline register
    logic       wb_stage_valid;
    logic       wb_regwrite;
    logic       wb_memtoreg;
    ridx_t      wb_dest;
    word_t      wb_alu;

    // ID decode
    ridx_t id_rs;
    ridx_t id_rt;
    ridx_t id_rd;
    word_t id_imm;
    word_t id_a;
    word_t id_rt_data;
    word_t id_b;
    ridx_t id_dest;

    logic  ex_fwd_ok_c;
    logic  load_use_c;
    logic  accept_c;
    word_t alu_result_c;
    logic  wb_valid_c;
    word_t wb_value_c;
    logic  unused_bits;

    assign id_rs   = bus.instruction[21 +: AW];
    assign id_rt   = bus.instruction[16 +: AW];
    assign id_rd   = bus.instruction[11 +: AW];
    assign id_imm  = WIDTH'($signed(bus.instruction[15:0]));
    assign id_b    = bus.ALUSrc ? id_imm : id_rt_data;
    assign id_dest = bus.RegDst ? id_rd : id_rt;

    // Opcode/funct are decoded upstream; only register fields and imm matter here
    assign unused_bits = ^{bus.instruction[31:26], bus.instruction[25:11]};

    // Only a non-load producer in EX can forward its ALU result
    assign ex_fwd_ok_c = ex_valid && ex_regwrite && !ex_memtoreg;

    // A load in EX cannot supply its value until WB; rt is always treated as read
    assign load_use_c = ex_valid && ex_memtoreg && ex_regwrite && (ex_dest != '0) &&
                        ((ex_dest == id_rs) || (ex_dest == id_rt));

    assign accept_c = bus.in_valid && !load_use_c;

    assign wb_valid_c = wb_stage_valid && wb_regwrite && (wb_dest != '0);
    assign wb_value_c = wb_memtoreg ? bus.mem_rdata : wb_alu;

    // rs operand: zero register, then EX forward, then WB forward, then register file
    always_comb begin
        id_a = rf[id_rs];
        if (id_rs == '0) begin
            id_a = '0;
        end else if (ex_fwd_ok_c && (ex_dest == id_rs)) begin
            id_a = alu_result_c;
        end else if (wb_valid_c && (wb_dest == id_rs)) begin
            id_a = wb_value_c;
        end
    end

    // rt operand: same priority as rs
    always_comb begin
        id_rt_data = rf[id_rt];
        if (id_rt == '0) begin
            id_rt_data = '0;
        end else if (ex_fwd_ok_c && (ex_dest == id_rt)) begin
            id_rt_data = alu_result_c;
        end else if (wb_valid_c && (wb_dest == id_rt)) begin
            id_rt_data = wb_value_c;
        end
    end

    // EX-stage ALU; undefined control codes give zero
    always_comb begin
        alu_result_c = '0;
        case (ex_aluctl)
            ALU_AND: alu_result_c = ex_a & ex_b;
            ALU_OR:  alu_result_c = ex_a | ex_b;
            ALU_ADD: alu_result_c = ex_a + ex_b;
            ALU_SUB: alu_result_c = ex_a - ex_b;
            ALU_SLT: alu_result_c = WIDTH'($signed(ex_a) < $signed(ex_b));
            ALU_NOR: alu_result_c = ~(ex_a | ex_b);
            default: alu_result_c = '0;
        endcase
    end

    // ID/EX register: load on accept, otherwise insert a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_dest     <= '0;
            ex_aluctl   <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_store    <= '0;
        end else begin
            ex_valid    <= accept_c;
            ex_regwrite <= accept_c && bus.RegWrite;
            ex_memtoreg <= accept_c && bus.MemToReg;
            if (accept_c) begin
                ex_dest   <= id_dest;
                ex_aluctl <= bus.ALUControl;
                ex_a      <= id_a;
                ex_b      <= id_b;
                ex_store  <= id_rt_data;
            end
        end
    end

    // EX/WB register: follows EX every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_stage_valid <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_memtoreg    <= 1'b0;
            wb_dest        <= '0;
            wb_alu         <= '0;
        end else begin
            wb_stage_valid <= ex_valid;
            wb_regwrite    <= ex_regwrite;
            wb_memtoreg    <= ex_memtoreg;
            wb_dest        <= ex_dest;
            wb_alu         <= alu_result_c;
        end
    end

    // Register file write from WB; r0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf <= '{default: '0};
        end else if (wb_valid_c) begin
            rf[wb_dest] <= wb_value_c;
        end
    end

    assign bus.in_ready  = !load_use_c;
    assign bus.ALUResult = alu_result_c;
    assign bus.out32     = ex_store;
    assign bus.Zero      = ex_valid && (alu_result_c == '0);
    assign bus.wb_valid  = wb_valid_c;
    assign bus.wb_addr   = 5'(wb_dest);
    assign bus.wb_data   = wb_value_c;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath against an in-order architectural model.
module tb_pipelined_datapath;
    localparam int unsigned W = 16;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_datapath_if #(.WIDTH(W)) bus ();
    pipelined_datapath #(.WIDTH(W), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // What the model says occupies a stage
    typedef struct {
        bit           v;
        bit           ld;
        bit           rw;
        logic [4:0]   dest;
        logic [W-1:0] alu;
        logic [W-1:0] st;
        logic [W-1:0] val;
    } slot_t;

    slot_t        ex_s, wb_s, cur_ex, cur_wb;
    logic [W-1:0] mreg [32];
    int           errors = 0;
    int           checks = 0;

    logic         obs_rdy, obs_zero, obs_wbv, exp_rdy, obs_acc;
    logic [W-1:0] obs_alu, obs_st, obs_wbd;
    logic [4:0]   obs_wba;

    function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_SLT:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            C_NOR:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        ex_s = '{default: 0};
        wb_s = '{default: 0};
    endtask

    // One clock: drive at negedge, observe 1ns later, advance model on the rising edge
    task automatic step(input bit v, input logic [31:0] instr, input bit alusrc, input bit regwrite,
                        input bit regdst, input bit memtoreg, input logic [3:0] ctl, input logic [W-1:0] memval);
        logic [4:0]   rs, rt, dst;
        logic [W-1:0] a, rtv, b, res;
        rs = instr[25:21];
        rt = instr[20:16];
        cur_ex = ex_s;
        cur_wb = wb_s;
        bus.in_valid    = v;
        bus.instruction = instr;
        bus.ALUSrc      = alusrc;
        bus.RegWrite    = regwrite;
        bus.RegDst      = regdst;
        bus.MemToReg    = memtoreg;
        bus.ALUControl  = ctl;
        bus.mem_rdata   = wb_s.ld ? wb_s.val : W'($urandom);
        exp_rdy = !(ex_s.v && ex_s.ld && ex_s.rw && ex_s.dest != 0 && (ex_s.dest == rs || ex_s.dest == rt));
        #1;
        obs_rdy  = bus.in_ready;
        obs_alu  = bus.ALUResult;
        obs_st   = bus.out32;
        obs_zero = bus.Zero;
        obs_wbv  = bus.wb_valid;
        obs_wba  = bus.wb_addr;
        obs_wbd  = bus.wb_data;
        @(posedge clk);
        obs_acc = v && obs_rdy;
        wb_s = ex_s;
        if (obs_acc) begin
            a   = (rs == 0) ? '0 : mreg[rs];
            rtv = (rt == 0) ? '0 : mreg[rt];
            b   = alusrc ? W'($signed(instr[15:0])) : rtv;
            res = alu_ref(ctl, a, b);
            dst = regdst ? instr[15:11] : rt;
            ex_s = '{v: 1, ld: memtoreg, rw: regwrite, dest: dst, alu: res, st: rtv,
                     val: memtoreg ? memval : res};
            if (regwrite && dst != 0) mreg[dst] = ex_s.val;
        end else begin
            ex_s = '{default: 0};
        end
        @(negedge clk);
    endtask

    task automatic step_idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, C_AND, '0);
    endtask

    task automatic step_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] c);
        step(1'b1, rtype(rs, rt, rd), 1'b0, 1'b1, 1'b1, 1'b0, c, '0);
    endtask

    task automatic step_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        step(1'b1, itype(6'h08, rs, rt, imm), 1'b1, 1'b1, 1'b0, 1'b0, C_ADD, '0);
    endtask

    task automatic step_lw(input logic [31:0] instr, input logic [W-1:0] memval);
        step(1'b1, instr, 1'b1, 1'b1, 1'b0, 1'b1, C_ADD, memval);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.ALUSrc = 1'b0; bus.RegWrite = 1'b0;
        bus.RegDst = 1'b0; bus.MemToReg = 1'b0; bus.ALUControl = '0; bus.mem_rdata = '0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.ALUResult !== '0) begin errors++; $display("FAIL reset.ALUResult got %h want 0", bus.ALUResult); end
        checks++; if (bus.out32 !== '0)     begin errors++; $display("FAIL reset.out32 got %h want 0", bus.out32); end
        checks++; if (bus.Zero !== 1'b0)    begin errors++; $display("FAIL reset.Zero got %b want 0", bus.Zero); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset.wb_valid got %b want 0", bus.wb_valid); end
        checks++; if (bus.wb_addr !== 5'd0) begin errors++; $display("FAIL reset.wb_addr got %h want 0", bus.wb_addr); end
        checks++; if (bus.wb_data !== '0)   begin errors++; $display("FAIL reset.wb_data got %h want 0", bus.wb_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset.in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_midstream();
        for (int x = 1; x < 32; x++) step_addi(5'(x), 5'd0, 16'(x * 37 + 1));
        rst = 1'b0;
        #1;
        checks++; if (bus.ALUResult !== '0 || bus.out32 !== '0 || bus.Zero !== 1'b0) begin
            errors++; $display("FAIL midreset.ex got alu=%h st=%h z=%b want 0 0 0", bus.ALUResult, bus.out32, bus.Zero);
        end
        checks++; if (bus.wb_valid !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== '0) begin
            errors++; $display("FAIL midreset.wb got v=%b a=%h d=%h want 0 0 0", bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset.in_ready got %b want 1", bus.in_ready); end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int x = 1; x <= 32; x++) begin
            if (x < 32) step_r(5'd0, 5'(x), 5'(x), C_ADD);
            else step_idle();
            if (cur_ex.v) begin
                checks++;
                if (obs_alu !== '0 || obs_st !== '0) begin
                    errors++; $display("FAIL midreset.read r%0d got alu=%h st=%h want 0 0", x - 1, obs_alu, obs_st);
                end
            end
        end
    endtask

    task automatic test_loads_then_add();
        step_lw(32'h8C010002, W'(2));
        step_lw(32'h8C020004, W'(4));
        checks++; if (obs_alu !== W'(2)) begin errors++; $display("FAIL lwadd.addr1 got %h want 0002", obs_alu); end
        step_idle();
        checks++; if (obs_alu !== W'(4)) begin errors++; $display("FAIL lwadd.addr2 got %h want 0004", obs_alu); end
        checks++; if (obs_wbv !== 1'b1 || obs_wba !== 5'd1 || obs_wbd !== W'(2)) begin
            errors++; $display("FAIL lwadd.wb1 got v=%b a=%0d d=%h want 1 1 0002", obs_wbv, obs_wba, obs_wbd);
        end
        step(1'b1, 32'h00220820, 1'b0, 1'b1, 1'b1, 1'b0, C_ADD, '0);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL lwadd.ready got %b want 1", obs_rdy); end
        step_idle();
        checks++; if (obs_alu !== W'(6)) begin errors++; $display("FAIL lwadd.sum got %h want 0006", obs_alu); end
        step_idle();
        checks++; if (obs_wbv !== 1'b1 || obs_wba !== 5'd1 || obs_wbd !== W'(6)) begin
            errors++; $display("FAIL lwadd.wb got v=%b a=%0d d=%h want 1 1 0006", obs_wbv, obs_wba, obs_wbd);
        end
    endtask

    task automatic test_ex_forwarding();
        step_addi(5'd3, 5'd0, 16'd5);
        step(1'b1, {6'd0, 5'd3, 5'd3, 5'd4, 5'd0, 6'h22}, 1'b0, 1'b1, 1'b1, 1'b0, C_SUB, '0);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL exfwd.ready got %b want 1", obs_rdy); end
        checks++; if (obs_alu !== W'(5)) begin errors++; $display("FAIL exfwd.addi got %h want 0005", obs_alu); end
        step_idle();
        checks++; if (obs_alu !== '0 || obs_zero !== 1'b1) begin
            errors++; $display("FAIL exfwd.sub got alu=%h z=%b want 0000 1", obs_alu, obs_zero);
        end
    endtask

    task automatic test_load_use_stall();
        step_lw(itype(6'h23, 5'd0, 5'd5, 16'h0010), W'(7));
        step_r(5'd5, 5'd5, 5'd6, C_ADD);
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL stall.first got ready=%b want 0", obs_rdy); end
        step_r(5'd5, 5'd5, 5'd6, C_ADD);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL stall.second got ready=%b want 1", obs_rdy); end
        step_idle();
        checks++; if (obs_alu !== W'(14)) begin errors++; $display("FAIL stall.sum got %h want 000e", obs_alu); end
    endtask

    task automatic test_r0_guard();
        step_addi(5'd0, 5'd0, 16'd9);
        step_r(5'd0, 5'd0, 5'd7, C_ADD);
        step_idle();
        checks++; if (obs_wbv !== 1'b0) begin errors++; $display("FAIL r0.wb_valid got %b want 0", obs_wbv); end
        checks++; if (obs_alu !== '0) begin errors++; $display("FAIL r0.add got %h want 0000", obs_alu); end
    endtask

    task automatic test_alu_ops();
        step_addi(5'd8, 5'd0, 16'h8000);
        step_addi(5'd9, 5'd0, 16'h0001);
        step_r(5'd8, 5'd9, 5'd10, C_SLT);
        step_r(5'd0, 5'd0, 5'd11, C_NOR);
        checks++; if (obs_alu !== W'(1)) begin errors++; $display("FAIL alu.slt got %h want 0001", obs_alu); end
        step_r(5'd8, 5'd9, 5'd12, 4'b1111);
        checks++; if (obs_alu !== 16'hFFFF) begin errors++; $display("FAIL alu.nor got %h want ffff", obs_alu); end
        step_idle();
        checks++; if (obs_alu !== '0 || obs_zero !== 1'b1) begin
            errors++; $display("FAIL alu.undef got alu=%h z=%b want 0000 1", obs_alu, obs_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   codes [8];
        logic [31:0]  ins;
        logic [4:0]   rs, rt, rd;
        logic [3:0]   c;
        logic [W-1:0] mv;
        bit           v, als, rw, rdst, mtr, hold, exp_wbv;
        int           k;
        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR, 4'b1111, 4'b0011};
        hold = 1'b0;
        v = 1'b0; ins = '0; als = 1'b0; rw = 1'b0; rdst = 1'b0; mtr = 1'b0; c = C_AND; mv = '0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                k  = $urandom_range(0, 9);
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                c  = codes[$urandom_range(0, 7)];
                mv = W'($urandom);
                v = 1'b1; als = 1'b1; rw = 1'b1; rdst = 1'b0; mtr = 1'b0;
                ins = itype(6'($urandom), rs, rt, 16'($urandom));
                if (k == 0) begin
                    v = 1'b0; ins = '0; rw = 1'b0;
                end else if (k <= 4) begin
                    ins = {6'd0, rs, rt, rd, 11'($urandom)}; als = 1'b0; rdst = 1'b1;
                end else if (k <= 6) begin
                    // I-type ALU with the random opcode/imm already built
                end else if (k <= 8) begin
                    mtr = 1'b1; c = C_ADD;
                end else begin
                    rw = 1'b0; c = C_ADD;
                end
            end
            step(v, ins, als, rw, rdst, mtr, c, mv);
            hold = v && !obs_acc;
            checks++; if (obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand.in_ready n=%0d got %b want %b", n, obs_rdy, exp_rdy);
            end
            if (cur_ex.v) begin
                checks++; if (obs_alu !== cur_ex.alu || obs_st !== cur_ex.st || obs_zero !== (cur_ex.alu == '0)) begin
                    errors++; $display("FAIL rand.ex n=%0d got alu=%h st=%h z=%b want %h %h %b",
                                       n, obs_alu, obs_st, obs_zero, cur_ex.alu, cur_ex.st, cur_ex.alu == '0);
                end
            end else begin
                checks++; if (obs_zero !== 1'b0) begin errors++; $display("FAIL rand.bubble_zero n=%0d got %b want 0", n, obs_zero); end
            end
            exp_wbv = cur_wb.v && cur_wb.rw && cur_wb.dest != 0;
            checks++; if (obs_wbv !== exp_wbv) begin
                errors++; $display("FAIL rand.wb_valid n=%0d got %b want %b", n, obs_wbv, exp_wbv);
            end
            if (exp_wbv) begin
                checks++; if (obs_wba !== cur_wb.dest || obs_wbd !== cur_wb.val) begin
                    errors++; $display("FAIL rand.wb n=%0d got a=%0d d=%h want %0d %h", n, obs_wba, obs_wbd, cur_wb.dest, cur_wb.val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads_then_add();
        test_ex_forwarding();
        test_load_use_stall();
        test_r0_guard();
        test_alu_ops();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
